// File: rtl/npu_port_arbiter.sv
// ---------------------------------------------------------------------------
// npu_port_arbiter
//
// Shares the single NPU memory port between NumReq requesters (for example
// the CPU-side bus interface and a DMA engine). At most one access is granted
// per cycle using round-robin priority. A granted requester can hold the port
// across several accesses with a burst lock. Read data comes back from the NPU
// one cycle after the access and is flagged to the requester that issued it.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_i        per-requester access request, held until granted
//   lock_i       per-requester burst lock, sampled when that requester wins
//   wen_i        per-requester write enable (1 = write, 0 = read)
//   addr_i       packed addresses, requester k at [k*DWidth +: DWidth]
//   wdata_i      packed write data, same slicing as addr_i
//   gnt_o        one-hot grant (combinational); access accepted this cycle
//   rvalid_o     one-hot read-data-valid, one cycle after a read grant
//   rdata_o      read data, straight from npu_rdata_i
//   npu_cen_o    NPU chip enable
//   npu_wen_o    NPU write enable
//   npu_addr_o   NPU address
//   npu_wdata_o  NPU write data
//   npu_rdata_i  NPU read data, valid one cycle after a read access
// ---------------------------------------------------------------------------
module npu_port_arbiter #(
    parameter  int DWidth = 32,
    parameter  int NumReq = 2,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]        lock_i,
    input  logic [NumReq-1:0]        wen_i,
    input  logic [NumReq*DWidth-1:0] addr_i,
    input  logic [NumReq*DWidth-1:0] wdata_i,
    output logic [NumReq-1:0]        gnt_o,
    output logic [NumReq-1:0]        rvalid_o,
    output logic [DWidth-1:0]        rdata_o,
    output logic                     npu_cen_o,
    output logic                     npu_wen_o,
    output logic [DWidth-1:0]        npu_addr_o,
    output logic [DWidth-1:0]        npu_wdata_o,
    input  logic [DWidth-1:0]        npu_rdata_i
);

    logic [IdxW-1:0] ptr_q;
    logic            lock_q;
    logic [IdxW-1:0] owner_q;
    logic            rd_pend_q;
    logic [IdxW-1:0] rd_idx_q;

    logic            grant_valid;
    logic [IdxW-1:0] win_idx;

    // Adds an offset to a requester index and wraps it back into 0..NumReq-1.
    // Offsets never exceed NumReq-1, so a single subtraction is enough even
    // when NumReq is not a power of two.
    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return IdxW'(sum);
    endfunction

    // Winner selection. A live burst lock pins the port to its owner; if the
    // owner has let go of its request the lock is ignored and the normal
    // round-robin scan runs. The scan walks from the highest offset down so
    // that the requester closest to ptr_q is the last, and winning, match.
    // Reset forces the grant off so nothing leaks onto the NPU port.
    always_comb begin
        grant_valid = 1'b0;
        win_idx     = '0;
        if (lock_q && req_i[owner_q]) begin
            grant_valid = 1'b1;
            win_idx     = owner_q;
        end else begin
            for (int i = NumReq - 1; i >= 0; i--) begin
                if (req_i[wrap_add(ptr_q, i)]) begin
                    grant_valid = 1'b1;
                    win_idx     = wrap_add(ptr_q, i);
                end
            end
        end
        if (rst_i) begin
            grant_valid = 1'b0;
        end
    end

    // Drive the NPU port and the grant vector from the winner. Everything is
    // held at zero when there is no grant so an idle port is clean.
    always_comb begin
        gnt_o       = '0;
        npu_cen_o   = 1'b0;
        npu_wen_o   = 1'b0;
        npu_addr_o  = '0;
        npu_wdata_o = '0;
        if (grant_valid) begin
            gnt_o[win_idx] = 1'b1;
            npu_cen_o      = 1'b1;
            npu_wen_o      = wen_i[win_idx];
            npu_addr_o     = addr_i[int'(win_idx)*DWidth +: DWidth];
            npu_wdata_o    = wdata_i[int'(win_idx)*DWidth +: DWidth];
        end
    end

    // Arbitration state. On a grant the priority pointer moves past the
    // winner, the lock is re-sampled from the winner, and a read is recorded
    // so its data can be flagged next cycle. On an idle cycle any read in
    // flight retires, and a lock whose owner has stopped requesting is
    // released. Reset drops a read in flight so it never produces rvalid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            owner_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
        end else if (grant_valid) begin
            ptr_q     <= wrap_add(win_idx, 1);
            lock_q    <= lock_i[win_idx];
            owner_q   <= win_idx;
            rd_pend_q <= ~wen_i[win_idx];
            rd_idx_q  <= win_idx;
        end else begin
            rd_pend_q <= 1'b0;
            if (!req_i[owner_q]) begin
                lock_q <= 1'b0;
            end
        end
    end

    // Read return. The valid bit is steered to the requester that issued the
    // read; the data itself is passed through untouched for every requester.
    always_comb begin
        rvalid_o           = '0;
        rvalid_o[rd_idx_q] = rd_pend_q;
        rdata_o            = npu_rdata_i;
    end

endmodule
